// File: rtl/clk_divider_pkg.sv
// clk_divider_pkg: shared sizing helper for the clock divider counter
package clk_divider_pkg;
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clk_divider_mod_n_counter.sv
// mod_n_counter: free-running modulo-N counter with a wrap flag on its last state
module mod_n_counter
  import clk_divider_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [cnt_width(N)-1:0]   cnt,
  output logic                      wrap
);
  localparam int CNT_W = cnt_width(N);
  assign wrap = cnt == CNT_W'(N - 1);
  // count 0..N-1 and restart from zero after the wrap state
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/clk_divider.sv
// clk_divider: registered 50%-duty divide-by-2*CONST_N output; CLK_DIVIDER_TICK_EN adds a rising-edge tick
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int CONST_N = 3
) (
  input  logic clk,
  input  logic rst,
  output logic clk_div
`ifdef CLK_DIVIDER_TICK_EN
  ,
  output logic tick
`endif
);
  localparam int CNT_W = cnt_width(CONST_N);
  if (CONST_N < 1) begin : g_bad_n
    $fatal(1, "clk_divider: CONST_N must be at least 1");
  end
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  mod_n_counter #(.N(CONST_N)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap)
  );
  a_cnt_range: assert property (@(posedge clk) cnt <= CNT_W'(CONST_N - 1));
  // flip the output each time a half-period of CONST_N cycles completes
  always_ff @(posedge clk)
    if (rst) clk_div <= 1'b0;
    else if (wrap) clk_div <= ~clk_div;
`ifdef CLK_DIVIDER_TICK_EN
  // pulse for the cycle in which clk_div goes low to high
  always_ff @(posedge clk)
    if (rst) tick <= 1'b0;
    else tick <= wrap & ~clk_div;
`endif
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: scoreboard bench for clk_divider at CONST_N = 1, 3, 4, 5
module tb_clk_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d1, d3, d4, d5;
`ifdef CLK_DIVIDER_TICK_EN
  logic t1, t3, t4, t5;
`endif
  always #5 clk = ~clk;

  clk_divider #(.CONST_N(1)) u_n1 (.clk(clk), .rst(rst), .clk_div(d1)
`ifdef CLK_DIVIDER_TICK_EN
    , .tick(t1)
`endif
  );
  clk_divider #(.CONST_N(3)) u_n3 (.clk(clk), .rst(rst), .clk_div(d3)
`ifdef CLK_DIVIDER_TICK_EN
    , .tick(t3)
`endif
  );
  clk_divider #(.CONST_N(4)) u_n4 (.clk(clk), .rst(rst), .clk_div(d4)
`ifdef CLK_DIVIDER_TICK_EN
    , .tick(t4)
`endif
  );
  clk_divider #(.CONST_N(5)) u_n5 (.clk(clk), .rst(rst), .clk_div(d5)
`ifdef CLK_DIVIDER_TICK_EN
    , .tick(t5)
`endif
  );

  typedef struct {
    logic [3:0] div;
    int         c1, c3, c4, c5;
    logic       tk;
  } exp_t;

  exp_t sb[$];
  int   k = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   run4 = 0, run5 = 0;
  logic seen4 = 1'b0, seen5 = 1'b0, last4 = 1'b0, last5 = 1'b0;

  function automatic logic mdl_div(input int n, input int kk);
    return ((kk / n) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    rst = r;
    k = r ? 0 : k + 1;
    e.div = {mdl_div(5, k), mdl_div(4, k), mdl_div(3, k), mdl_div(1, k)};
    e.c1 = 0;
    e.c3 = k % 3;
    e.c4 = k % 4;
    e.c5 = k % 5;
    e.tk = !r && (k % 6 == 3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("div_n1", 32'(d1), 32'(e.div[0]));
    chk("div_n3", 32'(d3), 32'(e.div[1]));
    chk("div_n4", 32'(d4), 32'(e.div[2]));
    chk("div_n5", 32'(d5), 32'(e.div[3]));
    chk("cnt_n1", 32'(u_n1.u_cnt.cnt), 32'(e.c1));
    chk("cnt_n3", 32'(u_n3.u_cnt.cnt), 32'(e.c3));
    chk("cnt_n4", 32'(u_n4.u_cnt.cnt), 32'(e.c4));
    chk("cnt_n5", 32'(u_n5.u_cnt.cnt), 32'(e.c5));
`ifdef CLK_DIVIDER_TICK_EN
    chk("tick_n3", 32'(t3), 32'(e.tk));
`endif
    if (r) begin
      seen4 = 1'b0; seen5 = 1'b0; run4 = 0; run5 = 0; last4 = 1'b0; last5 = 1'b0;
    end else begin
      if (d4 !== last4) begin
        if (seen4) chk("run_n4", 32'(run4), 32'd4);
        seen4 = 1'b1; run4 = 1; last4 = d4;
      end else run4++;
      if (d5 !== last5) begin
        if (seen5) chk("run_n5", 32'(run5), 32'd5);
        seen5 = 1'b1; run5 = 1; last5 = d5;
      end else run5++;
    end
  endtask

  initial begin
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 21; i++) step(1'b0);
    chk("pre_reset_high_n3", 32'(d3), 32'd1);
    step(1'b1);
    chk("mid_reset_low_n3", 32'(d3), 32'd0);
    step(1'b1);
    for (int i = 0; i < 14; i++) step(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1);
    for (int i = 0; i < 40; i++) step(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
